// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display multiplexer.
// Holds the segment bit order (a..g, dp from MSB to LSB), the blank pattern
// and the 16 active-low hex glyphs (7 bits, a in bit 6 .. g in bit 0).
package seven_seg_pkg;

   localparam int unsigned SEG_W   = 8;
   localparam int unsigned GLYPH_W = 7;
   localparam int unsigned HEX_W   = 4;

   // Segment bus bit order: seg[7]=a ... seg[1]=g, seg[0]=dp; all active-low.
   typedef struct packed {
      logic a;
      logic b;
      logic c;
      logic d;
      logic e;
      logic f;
      logic g;
      logic dp;
   } seg_t;

   localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

   localparam logic [GLYPH_W-1:0] GLYPH_0 = 7'h01;
   localparam logic [GLYPH_W-1:0] GLYPH_1 = 7'h4F;
   localparam logic [GLYPH_W-1:0] GLYPH_2 = 7'h12;
   localparam logic [GLYPH_W-1:0] GLYPH_3 = 7'h06;
   localparam logic [GLYPH_W-1:0] GLYPH_4 = 7'h4C;
   localparam logic [GLYPH_W-1:0] GLYPH_5 = 7'h24;
   localparam logic [GLYPH_W-1:0] GLYPH_6 = 7'h20;
   localparam logic [GLYPH_W-1:0] GLYPH_7 = 7'h0F;
   localparam logic [GLYPH_W-1:0] GLYPH_8 = 7'h00;
   localparam logic [GLYPH_W-1:0] GLYPH_9 = 7'h04;
   localparam logic [GLYPH_W-1:0] GLYPH_A = 7'h08;
   localparam logic [GLYPH_W-1:0] GLYPH_B = 7'h60;
   localparam logic [GLYPH_W-1:0] GLYPH_C = 7'h31;
   localparam logic [GLYPH_W-1:0] GLYPH_D = 7'h42;
   localparam logic [GLYPH_W-1:0] GLYPH_E = 7'h30;
   localparam logic [GLYPH_W-1:0] GLYPH_F = 7'h38;

endpackage

// File: rtl/seven_seg_if.sv
// Display-multiplexer bus bundle.
//   value : hex digits to load (digit i = value[4i+3:4i])
//   dp    : decimal point requests, active-high
//   load  : one-cycle capture strobe
//   blank : level, forces all anodes off
//   seg   : active-low segments a..g,dp
//   an    : active-low anode enables
//   busy  : a captured load is waiting for the frame boundary
//   frame : one-cycle pulse at each frame boundary
// master = the host driving the display, slave = the multiplexer.
interface seven_seg_if #(
   parameter int unsigned NDIG = 4
);
   logic [4*NDIG-1:0] value;
   logic [NDIG-1:0]   dp;
   logic              load;
   logic              blank;
   logic [7:0]        seg;
   logic [NDIG-1:0]   an;
   logic              busy;
   logic              frame;

   modport master (
      output value, dp, load, blank,
      input  seg, an, busy, frame
   );

   modport slave (
      input  value, dp, load, blank,
      output seg, an, busy, frame
   );
endinterface

// File: rtl/seven_seg_hex_to_seg.sv
// Combinational hex digit to active-low glyph decoder.
//   hex_i : 4-bit hex digit
//   seg_o : glyph, bit 6 = a ... bit 0 = g, active-low
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [HEX_W-1:0]   hex_i,
   output logic [GLYPH_W-1:0] seg_o
);

   always_comb begin
      seg_o = GLYPH_0;
      case (hex_i)
         4'h0: seg_o = GLYPH_0;
         4'h1: seg_o = GLYPH_1;
         4'h2: seg_o = GLYPH_2;
         4'h3: seg_o = GLYPH_3;
         4'h4: seg_o = GLYPH_4;
         4'h5: seg_o = GLYPH_5;
         4'h6: seg_o = GLYPH_6;
         4'h7: seg_o = GLYPH_7;
         4'h8: seg_o = GLYPH_8;
         4'h9: seg_o = GLYPH_9;
         4'hA: seg_o = GLYPH_A;
         4'hB: seg_o = GLYPH_B;
         4'hC: seg_o = GLYPH_C;
         4'hD: seg_o = GLYPH_D;
         4'hE: seg_o = GLYPH_E;
         default: seg_o = GLYPH_F;
      endcase
   end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed seven-segment display driver.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seven_seg_if.slave (value/dp/load/blank in, seg/an/busy/frame out)
// Each digit owns a slot of 2^PSW cycles; anodes stay off for the first DEAD
// cycles of a slot. Loads are staged in pending registers and applied to the
// display only at frame boundaries so a frame never mixes two values.
// Build option: define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_mux
   import seven_seg_pkg::*;
#(
   parameter int unsigned NDIG = 4,
   parameter int unsigned PSW  = 17,
   parameter int unsigned DEAD = 256
)(
   input  logic       clk,
   input  logic       rst,
   seven_seg_if.slave bus
);

   localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned VALW = 4 * NDIG;
   localparam logic [PSW-1:0]  PS_MAX   = '1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

   logic [PSW-1:0]  ps_q, ps_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [VALW-1:0] disp_val_q, disp_val_d;
   logic [NDIG-1:0] disp_dp_q, disp_dp_d;
   logic [VALW-1:0] pend_val_q, pend_val_d;
   logic [NDIG-1:0] pend_dp_q, pend_dp_d;
   logic            busy_q, busy_d;
   logic            frame_q, frame_d;
   logic [NDIG-1:0] an_q, an_d;
   seg_t            seg_q, seg_d;

   logic               tick_c;
   logic               boundary_c;
   logic [HEX_W-1:0]   digit_c;
   logic               dp_sel_c;
   logic               sup_sel_c;
   logic [NDIG-1:0]    sup_c;
   logic               active_c;
   logic [GLYPH_W-1:0] glyph_c;

   hex_to_seg u_hex_to_seg (
      .hex_i (digit_c),
      .seg_o (glyph_c)
   );

   // Per-digit suppression mask.
   always_comb begin
      sup_c = '0;
`ifdef SEVEN_SEG_LZB_EN
      // Digit i>0 is dark when it and every digit to its left are zero.
      for (int i = 1; i < NDIG; i++) begin
         sup_c[i] = 1'b1;
         for (int j = i; j < NDIG; j++) begin
            if (disp_val_q[4*j +: 4] != 4'h0) sup_c[i] = 1'b0;
         end
      end
`endif
   end

   // Timing, load staging and registered display outputs.
   always_comb begin
      tick_c     = (ps_q == PS_MAX);
      boundary_c = tick_c && (idx_q == IDX_LAST);

      ps_d  = ps_q + PSW'(1);
      idx_d = idx_q;
      if (tick_c) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);

      // Registered pulse lands on the boundary cycle itself.
      frame_d = (ps_d == PS_MAX) && (idx_d == IDX_LAST);

      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      busy_d     = busy_q;
      if (boundary_c) begin
         // A load on the boundary itself bypasses staging and beats any pending value.
         if (bus.load) begin
            disp_val_d = bus.value;
            disp_dp_d  = bus.dp;
         end else if (busy_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
         end
         busy_d = 1'b0;
      end else if (bus.load) begin
         pend_val_d = bus.value;
         pend_dp_d  = bus.dp;
         busy_d     = 1'b1;
      end

      digit_c   = '0;
      dp_sel_c  = 1'b0;
      sup_sel_c = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_q == IDXW'(i)) begin
            digit_c   = disp_val_q[4*i +: 4];
            dp_sel_c  = disp_dp_q[i];
            sup_sel_c = sup_c[i];
         end
      end

      active_c = (ps_q >= PSW'(DEAD)) && !bus.blank && !sup_sel_c;

      an_d = '1;
      for (int i = 0; i < NDIG; i++) begin
         if (active_c && (idx_q == IDXW'(i))) an_d[i] = 1'b0;
      end

      seg_d = seg_t'(SEG_OFF);
      if (active_c) seg_d = seg_t'({glyph_c, ~dp_sel_c});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ps_q       <= '0;
         idx_q      <= '0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         busy_q     <= 1'b0;
         frame_q    <= 1'b0;
         an_q       <= '1;
         seg_q      <= seg_t'(SEG_OFF);
      end else begin
         ps_q       <= ps_d;
         idx_q      <= idx_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         busy_q     <= busy_d;
         frame_q    <= frame_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign bus.seg   = seg_q;
   assign bus.an    = an_q;
   assign bus.busy  = busy_q;
   assign bus.frame = frame_q;

endmodule

// File: doc/seven_seg_mux.md
SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

Interface
REQ-001 Parameter NDIG, default 4, number of multiplexed digits (range 1..8).
REQ-002 Parameter PSW, default 17, prescaler width; each digit slot lasts 2^PSW clk cycles.
REQ-003 Parameter DEAD, default 256, anode dead-time in cycles at the start of each slot (range 0..2^PSW-1).
REQ-004 Port clk  input  1  system clock; all logic on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port value  input  4*NDIG  hex digits; digit i is value[4i+3:4i], digit 0 rightmost.
REQ-007 Port dp  input  NDIG  decimal point request per digit, active-high.
REQ-008 Port load  input  1  one-cycle strobe that captures value and dp.
REQ-009 Port blank  input  1  level; forces all anodes off while high.
REQ-010 Port seg  output  8  segments, active-low; bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-011 Port an  output  NDIG  anode enables, active-low; an[i] drives digit i.
REQ-012 Port busy  output  1  high while a captured load waits for a frame boundary.
REQ-013 Port frame  output  1  one-cycle pulse at every frame boundary.

Function
REQ-014 Prescaler ps shall count 0..2^PSW-1 and wrap; tick = (ps == 2^PSW-1).
REQ-015 Digit index idx shall advance on tick and wrap from NDIG-1 to 0.
REQ-016 A frame boundary is a tick with idx == NDIG-1; frame shall be high on exactly that cycle.
REQ-017 On load, value and dp shall go to pending registers and busy shall rise next cycle; a later load while busy overwrites the pending registers (last wins).
REQ-018 At a frame boundary with busy high, the pending registers shall go to the display registers and busy shall clear; the display registers change only at frame boundaries.
REQ-019 If load coincides with a frame boundary, the new value and dp shall go straight to the display registers and busy shall stay low.
REQ-020 an and seg shall be registered with one cycle of latency from (ps, idx, display registers, blank).
REQ-021 Digit idx is active when ps >= DEAD, blank is low, and the digit is not suppressed; then an has only bit idx low, otherwise an is all ones.
REQ-022 seg[7:1] shall be the standard hex glyph for display digit idx (0-9, A, b, C, d, E, F); seg[0] shall be the inverse of display dp[idx].
REQ-023 When no digit is active, seg shall be 8'hFF.
REQ-024 A change on blank shall affect an within one cycle and shall not disturb ps, idx, busy or the display registers.

Reset
REQ-025 While rst is high: ps=0, idx=0, display and pending registers=0, busy=0, frame=0, an=all ones, seg=8'hFF.
REQ-026 A pending load shall be discarded if reset occurs mid-frame, and load shall be ignored while rst is high.
REQ-027 After rst falls, the first tick shall occur 2^PSW cycles later.

Configuration
REQ-028 Macro SEVEN_SEG_LZB_EN: when defined, leading-zero blanking is enabled; digit i>0 is suppressed when display digits i..NDIG-1 are all zero, and its dp is suppressed with it; digit 0 is never suppressed.
REQ-029 When SEVEN_SEG_LZB_EN is undefined, no digit is ever suppressed.

Structure
REQ-030 A shared package seven_seg_pkg shall hold the 16 active-low glyph constants, SEG_OFF=8'hFF, and the segment bit-order definition.
REQ-031 Sub-module hex_to_seg (4-bit in, 7-bit active-low out, combinational) shall be instantiated once.

Verification (NDIG=4, PSW=3, DEAD=1; slot 8 cycles, frame 32 cycles)
REQ-032 Reset, then load value=16'h4321, dp=0 -> after the first frame boundary, each slot shows an=1110/1101/1011/0111 with seg=9F/25/0D/99, and an=1111 in the first cycle of each slot.
REQ-033 Load 16'hABCD mid-frame, then 16'h00EF while busy -> busy held to the boundary; only 00EF is displayed; with the macro defined an[3:2] stay high, without it digits 3:2 show seg=03.
REQ-034 Load coincident with frame pulse -> display registers update on that cycle; busy never rises.
REQ-035 dp=4'b0100, value=16'h8888 -> digit 2 shows seg=00 and the other digits show seg=01.
REQ-036 Assert blank for 10 cycles mid-slot -> an=1111 and seg=FF one cycle later; idx and frame timing are unchanged after release.
REQ-037 Assert rst while busy -> busy=0, an=1111, seg=FF; the pending value is never displayed.
